spec_acc_seq: RTL and testbench

- Parametrised successor to the spectrum-accumulator controller.
- Sequences multi-pulse, multi-range-bin spectral accumulation in a read-modify-write DPRAM (FFT bins x range bins).
- Tracks range bin and pulse count internally and aligns the write path to a configurable read/adder latency.
- Flags bin, pulse and frame completion. Sits between the FFT output stage and the accumulation DPRAM/adder.

---
 rtl/spec_acc_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_spec_acc_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spec_acc_seq.sv
// spec_acc_seq: sequencer for multi-pulse, multi-range-bin spectral
// accumulation in a read-modify-write DPRAM addressed as {range bin, FFT index}.
//
// Ports:
//   clk, rst (async, active-low)  clock and reset
//   start, n_pulses               arm a frame of n_pulses pulses (0 means 1)
//   data_valid_in, data_index     FFT output samples
//   rd_addr_out                   DPRAM read address, one cycle after the sample
//   wr_addr_out, dpram_wea,       write side, issued RD_LAT cycles after the
//   acc_sel                       matching read (acc_sel=0 overwrites)
//   bin_done, pulse_done,         completion pulses
//   frame_done
//   busy, pulse_count             frame in progress, completed pulses
//
// Optional build macro SPEC_ACC_READOUT_EN adds ro_start / ro_valid / ro_last
// and a READOUT state that sweeps the whole RAM once after a completed frame.
module spec_acc_seq #(
  parameter int IDX_W  = 10,
  parameter int BIN_W  = 5,
  parameter int NBINS  = 20,
  parameter int RD_LAT = 3,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_W-1:0]       n_pulses,
  input  logic                   data_valid_in,
  input  logic [IDX_W-1:0]       data_index,
`ifdef SPEC_ACC_READOUT_EN
  input  logic                   ro_start,
  output logic                   ro_valid,
  output logic                   ro_last,
`endif
  output logic [BIN_W+IDX_W-1:0] rd_addr_out,
  output logic [BIN_W+IDX_W-1:0] wr_addr_out,
  output logic                   acc_sel,
  output logic                   dpram_wea,
  output logic                   bin_done,
  output logic                   pulse_done,
  output logic                   frame_done,
  output logic                   busy,
  output logic [CNT_W-1:0]       pulse_count
);
  localparam int AW = BIN_W + IDX_W;
  localparam logic [IDX_W-1:0] IDX_MAX  = '1;
  localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(NBINS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACC     = 3'd1,
    S_FLUSH   = 3'd2,
`ifdef SPEC_ACC_READOUT_EN
    S_READOUT = 3'd4,
`endif
    S_DONE    = 3'd3
  } state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_npulses, r_pulse_cnt;
  logic [BIN_W-1:0] r_bin_cnt;
  logic [AW-1:0]    r_rd_addr;
  logic             r_busy, r_frame_done;
  logic             w_accept, w_bin_end, w_pulse_end;

  // Write-side delay line; stage 0 loads with the read, stage RD_LAT drives
  // the write port, so the write trails its read by exactly RD_LAT cycles.
  logic             r_dl_v   [0:RD_LAT];
  logic [AW-1:0]    r_dl_addr[0:RD_LAT];
  logic             r_dl_acc [0:RD_LAT];
  logic             r_dl_be  [0:RD_LAT];
  logic             r_dl_pe  [0:RD_LAT];

  assign w_accept    = (r_state == S_ACC) && data_valid_in;
  assign w_bin_end   = w_accept && (data_index == IDX_MAX);
  assign w_pulse_end = w_bin_end && (r_bin_cnt == BIN_LAST);

`ifdef SPEC_ACC_READOUT_EN
  localparam logic [AW-1:0] RO_LAST = AW'(NBINS * (2 ** IDX_W) - 1);
  logic          r_frame_seen, r_ro_active;
  logic [AW-1:0] r_ro_cnt;
  logic          r_ro_v[0:RD_LAT-1];
  logic          r_ro_l[0:RD_LAT-1];
  logic          w_ro_issue;

  assign w_ro_issue = (r_state == S_READOUT) && r_ro_active;
`endif

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_ACC;
`ifdef SPEC_ACC_READOUT_EN
        else if (ro_start && r_frame_seen) w_next = S_READOUT;
`endif
        else w_next = S_IDLE;
      end
      S_ACC: begin
        if (w_pulse_end) w_next = S_FLUSH;
        else w_next = S_ACC;
      end
      S_FLUSH: begin
        // The pulse-end write is on the port now and pulse_count already
        // includes it, so the frame-end decision sees the updated count.
        if (r_dl_pe[RD_LAT]) begin
          if (r_pulse_cnt >= r_npulses) w_next = S_DONE;
          else w_next = S_ACC;
        end else begin
          w_next = S_FLUSH;
        end
      end
      S_DONE: w_next = S_IDLE;
`ifdef SPEC_ACC_READOUT_EN
      S_READOUT: begin
        if (r_ro_l[RD_LAT-1]) w_next = S_IDLE;
        else w_next = S_READOUT;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // State, frame counters and read address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_npulses    <= '0;
      r_pulse_cnt  <= '0;
      r_bin_cnt    <= '0;
      r_rd_addr    <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_busy       <= (w_next != S_IDLE) && (w_next != S_DONE);
      r_frame_done <= (w_next == S_DONE);
      if ((r_state == S_IDLE) && start) begin
        r_npulses   <= (n_pulses == '0) ? CNT_W'(1) : n_pulses;
        r_pulse_cnt <= '0;
        r_bin_cnt   <= '0;
      end else begin
        // Count the pulse as its marked write moves onto the port.
        if (r_dl_pe[RD_LAT-1] && (r_pulse_cnt != CNT_MAX))
          r_pulse_cnt <= r_pulse_cnt + CNT_W'(1);
        if (w_bin_end)
          r_bin_cnt <= w_pulse_end ? '0 : r_bin_cnt + BIN_W'(1);
      end
      if (w_accept) r_rd_addr <= {r_bin_cnt, data_index};
`ifdef SPEC_ACC_READOUT_EN
      else if (w_ro_issue) r_rd_addr <= r_ro_cnt;
`endif
    end
  end

  // Write-side delay line shift
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= RD_LAT; i++) begin
        r_dl_v[i]    <= 1'b0;
        r_dl_addr[i] <= '0;
        r_dl_acc[i]  <= 1'b0;
        r_dl_be[i]   <= 1'b0;
        r_dl_pe[i]   <= 1'b0;
      end
    end else begin
      r_dl_v[0]    <= w_accept;
      r_dl_addr[0] <= {r_bin_cnt, data_index};
      r_dl_acc[0]  <= w_accept && (r_pulse_cnt != '0);
      r_dl_be[0]   <= w_bin_end;
      r_dl_pe[0]   <= w_pulse_end;
      for (int i = 1; i <= RD_LAT; i++) begin
        r_dl_v[i]    <= r_dl_v[i-1];
        r_dl_addr[i] <= r_dl_addr[i-1];
        r_dl_acc[i]  <= r_dl_acc[i-1];
        r_dl_be[i]   <= r_dl_be[i-1];
        r_dl_pe[i]   <= r_dl_pe[i-1];
      end
    end
  end

`ifdef SPEC_ACC_READOUT_EN
  // Readout sweep address generator and valid/last alignment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_seen <= 1'b0;
      r_ro_active  <= 1'b0;
      r_ro_cnt     <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_ro_v[i] <= 1'b0;
        r_ro_l[i] <= 1'b0;
      end
    end else begin
      if (r_state == S_DONE) r_frame_seen <= 1'b1;
      if ((r_state == S_IDLE) && (w_next == S_READOUT)) begin
        r_ro_active <= 1'b1;
        r_ro_cnt    <= '0;
      end else if (w_ro_issue) begin
        r_ro_cnt <= r_ro_cnt + AW'(1);
        if (r_ro_cnt == RO_LAST) r_ro_active <= 1'b0;
      end
      r_ro_v[0] <= w_ro_issue;
      r_ro_l[0] <= w_ro_issue && (r_ro_cnt == RO_LAST);
      for (int i = 1; i < RD_LAT; i++) begin
        r_ro_v[i] <= r_ro_v[i-1];
        r_ro_l[i] <= r_ro_l[i-1];
      end
    end
  end

  assign ro_valid = r_ro_v[RD_LAT-1];
  assign ro_last  = r_ro_l[RD_LAT-1];
`endif

  assign rd_addr_out = r_rd_addr;
  assign wr_addr_out = r_dl_addr[RD_LAT];
  assign acc_sel     = r_dl_acc[RD_LAT];
  assign dpram_wea   = r_dl_v[RD_LAT];
  assign bin_done    = r_dl_be[RD_LAT];
  assign pulse_done  = r_dl_pe[RD_LAT];
  assign frame_done  = r_frame_done;
  assign busy        = r_busy;
  assign pulse_count = r_pulse_cnt;

endmodule

// File: tb/tb_spec_acc_seq.sv
// Self-checking bench for spec_acc_seq (IDX_W=4, NBINS=2, RD_LAT=3).
// A transaction-level model predicts every write (address, acc flag, bin/pulse
// markers) as a queue entry due RD_LAT cycles after its read, plus pulse_count,
// frame_done, busy and rd_addr, and compares all of them every cycle.
module tb_spec_acc_seq;
  localparam int IDX_W  = 4;
  localparam int BIN_W  = 2;
  localparam int NBINS  = 2;
  localparam int RD_LAT = 3;
  localparam int CNT_W  = 8;
  localparam int AW     = BIN_W + IDX_W;
  localparam int NPTS   = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] n_pulses = '0;
  logic             data_valid_in = 1'b0;
  logic [IDX_W-1:0] data_index = '0;
  logic [AW-1:0]    rd_addr_out, wr_addr_out;
  logic             acc_sel, dpram_wea, bin_done, pulse_done, frame_done, busy;
  logic [CNT_W-1:0] pulse_count;
`ifdef SPEC_ACC_READOUT_EN
  localparam int TOT = NBINS * NPTS;
  logic ro_start = 1'b0;
  logic ro_valid, ro_last;
  int   m_ro = -1000;
  bit   m_fr_seen = 1'b0;
`endif

  spec_acc_seq #(.IDX_W(IDX_W), .BIN_W(BIN_W), .NBINS(NBINS), .RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .n_pulses(n_pulses),
    .data_valid_in(data_valid_in), .data_index(data_index),
`ifdef SPEC_ACC_READOUT_EN
    .ro_start(ro_start), .ro_valid(ro_valid), .ro_last(ro_last),
`endif
    .rd_addr_out(rd_addr_out), .wr_addr_out(wr_addr_out), .acc_sel(acc_sel),
    .dpram_wea(dpram_wea), .bin_done(bin_done), .pulse_done(pulse_done),
    .frame_done(frame_done), .busy(busy), .pulse_count(pulse_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic          acc;
    logic          bd;
    logic          pd;
  } wr_t;

  wr_t           exp_q[$];
  int            tests = 0, fails = 0, cyc_n = 0;
  bit            m_in_frame, m_open;
  int            m_np, m_fed, m_bin, m_pc, m_fd_due, m_idle_from;
  logic [AW-1:0] m_rd;
  int            wr_seen, fd_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_in_frame  = 1'b0;
    m_open      = 1'b0;
    m_np        = 1;
    m_fed       = 0;
    m_bin       = 0;
    m_pc        = 0;
    m_fd_due    = -1;
    m_idle_from = 0;
    m_rd        = '0;
`ifdef SPEC_ACC_READOUT_EN
    m_ro      = -1000;
    m_fr_seen = 1'b0;
`endif
  endtask

  // One clock cycle: drive, clock, advance the model, compare everything.
  task automatic cyc(input logic v, input logic [IDX_W-1:0] idx, input logic st,
                     input logic [CNT_W-1:0] np);
    bit  was_open, wr, exp_busy;
    wr_t w, e;
    data_valid_in = v;
    data_index    = idx;
    start         = st;
    n_pulses      = np;
    @(posedge clk);
    #1;
    cyc_n++;
    was_open = m_open;
    wr = 1'b0;
    if (!rst) begin
      model_reset();
    end else begin
      if (st && !m_in_frame && cyc_n >= m_idle_from) begin
        m_in_frame = 1'b1;
        m_open     = 1'b1;
        m_np       = (np == '0) ? 1 : int'(np);
        m_pc       = 0;
        m_bin      = 0;
        m_fed      = 0;
      end
`ifdef SPEC_ACC_READOUT_EN
      if (ro_start && !st && !m_in_frame && m_fr_seen && cyc_n >= m_idle_from) begin
        m_ro        = cyc_n;
        m_idle_from = cyc_n + TOT + RD_LAT + 1;
      end
      if (cyc_n >= m_ro + 1 && cyc_n <= m_ro + TOT) m_rd = AW'(cyc_n - m_ro - 1);
`endif
      if (v && was_open) begin
        w.due  = cyc_n + RD_LAT;
        w.addr = AW'(m_bin * NPTS + int'(idx));
        w.acc  = (m_fed != 0);
        w.bd   = (int'(idx) == NPTS - 1);
        w.pd   = 1'b0;
        m_rd   = w.addr;
        if (w.bd) begin
          m_bin++;
          if (m_bin == NBINS) begin
            m_bin  = 0;
            w.pd   = 1'b1;
            m_fed++;
            m_open = 1'b0;
          end
        end
        exp_q.push_back(w);
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc_n) begin
        e  = exp_q.pop_front();
        wr = 1'b1;
        if (e.pd) begin
          m_pc++;
          if (m_pc >= m_np) m_fd_due = cyc_n + 1;
        end
      end
      if (cyc_n == m_fd_due) begin
        m_in_frame  = 1'b0;
        m_idle_from = cyc_n + 2;
`ifdef SPEC_ACC_READOUT_EN
        m_fr_seen = 1'b1;
`endif
      end
    end
    exp_busy = m_in_frame;
`ifdef SPEC_ACC_READOUT_EN
    if (cyc_n >= m_ro && cyc_n <= m_ro + TOT - 1 + RD_LAT) exp_busy = 1'b1;
    chk("ro_valid", ro_valid, (cyc_n >= m_ro + RD_LAT) && (cyc_n <= m_ro + TOT - 1 + RD_LAT));
    chk("ro_last", ro_last, cyc_n == m_ro + TOT - 1 + RD_LAT);
`endif
    chk("wea", dpram_wea, wr);
    if (wr) begin
      chk("wr_addr", wr_addr_out, e.addr);
      chk("acc_sel", acc_sel, e.acc);
    end
    chk("bin_done", bin_done, wr && e.bd);
    chk("pulse_done", pulse_done, wr && e.pd);
    chk("pulse_count", pulse_count, m_pc);
    chk("frame_done", frame_done, cyc_n == m_fd_due);
    chk("busy", busy, exp_busy);
    chk("rd_addr", rd_addr_out, m_rd);
    if (dpram_wea) wr_seen++;
    if (frame_done) fd_seen++;
  endtask

  task automatic idle_until_ready();
    while (cyc_n + 1 < m_idle_from) cyc(1'b0, '0, 1'b0, '0);
  endtask

  // mode 0: contiguous, 1: one on / two off, 2: random gaps and indices
  task automatic run_frame(input int np, input int mode, input bit busy_start);
    int               guard, nsamp;
    logic [IDX_W-1:0] idx;
    idle_until_ready();
    wr_seen = 0;
    fd_seen = 0;
    cyc(1'b0, '0, 1'b1, CNT_W'(np));
    nsamp = 0;
    guard = 0;
    while (m_in_frame && guard < 200) begin
      if (m_open) begin
        for (int b = 0; b < NBINS; b++) begin
          for (int i = 0; i < NPTS; i++) begin
            if (mode == 1) repeat (2) cyc(1'b0, IDX_W'($urandom), 1'b0, '0);
            else if (mode == 2) repeat ($urandom_range(0, 2)) cyc(1'b0, IDX_W'($urandom), 1'b0, '0);
            if (i == NPTS - 1) idx = IDX_W'(NPTS - 1);
            else if (mode == 2 && $urandom_range(0, 3) == 0) idx = IDX_W'($urandom_range(0, NPTS - 2));
            else idx = IDX_W'(i);
            nsamp++;
            cyc(1'b1, idx, busy_start && (nsamp == 5), CNT_W'(7));
          end
        end
        // Valid samples during the flush window must be ignored.
        repeat (RD_LAT) cyc(1'($urandom_range(0, 1)), IDX_W'($urandom), 1'b0, '0);
        repeat (2) cyc(1'b0, '0, 1'b0, '0);
        if (m_in_frame && m_fed < m_np) m_open = 1'b1;
      end else begin
        cyc(1'b0, '0, 1'b0, '0);
        guard++;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc_n);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst = 1'b0;
    repeat (2) cyc(1'b0, '0, 1'b0, '0);
    rst = 1'b1;

    // Valid samples while idle produce nothing.
    repeat (3) cyc(1'b1, IDX_W'($urandom), 1'b0, '0);

    // One pulse, contiguous samples.
    run_frame(1, 0, 1'b0);
    chk("writes_np1", wr_seen, 32);
    chk("frames_np1", fd_seen, 1);

    // Three pulses: overwrite then accumulate.
    run_frame(3, 0, 1'b0);
    chk("writes_np3", wr_seen, 96);
    chk("frames_np3", fd_seen, 1);

    // n_pulses = 0 behaves as one pulse.
    run_frame(0, 0, 1'b0);
    chk("writes_np0", wr_seen, 32);

    // start while busy is ignored and n_pulses is not re-latched.
    run_frame(2, 0, 1'b1);
    chk("writes_busy_start", wr_seen, 64);
    chk("frames_busy_start", fd_seen, 1);

    // Gapped valids with noise during flush.
    run_frame(2, 1, 1'b0);
    chk("writes_gapped", wr_seen, 64);

    // Random gaps and out-of-order indices.
    for (int k = 0; k < 3; k++) begin
      run_frame(int'($urandom_range(1, 3)), 2, 1'b0);
    end

    // Reset in the middle of a burst with writes in flight.
    idle_until_ready();
    cyc(1'b0, '0, 1'b1, CNT_W'(1));
    for (int i = 0; i < 9; i++) cyc(1'b1, IDX_W'(i), 1'b0, '0);
    data_valid_in = 1'b1;
    data_index    = IDX_W'(9);
    rst = 1'b0;
    #1;
    chk("rst_rd_addr", rd_addr_out, 0);
    chk("rst_wr_addr", wr_addr_out, 0);
    chk("rst_acc_sel", acc_sel, 0);
    chk("rst_wea", dpram_wea, 0);
    chk("rst_bin_done", bin_done, 0);
    chk("rst_pulse_done", pulse_done, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulse_count", pulse_count, 0);
    cyc(1'b1, IDX_W'(10), 1'b0, '0);
    cyc(1'b1, IDX_W'(11), 1'b0, '0);
    rst = 1'b1;
    for (int i = 12; i < 16; i++) cyc(1'b1, IDX_W'(i), 1'b0, '0);
    run_frame(1, 0, 1'b0);
    chk("writes_after_reset", wr_seen, 32);

`ifdef SPEC_ACC_READOUT_EN
    idle_until_ready();
    ro_start = 1'b1;
    cyc(1'b0, '0, 1'b0, '0);
    ro_start = 1'b0;
    repeat (TOT + RD_LAT + 3) cyc(1'b0, '0, 1'b0, '0);
`endif

    repeat (3) cyc(1'b0, '0, 1'b0, '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
